// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the program counter, reads a word-addressed combinational instruction memory and
// pushes {pc, instr} pairs into a small FIFO that decode drains with a valid/ready handshake.
// Stops fetching (HALT) on an all-zero word and faults (FAULT) on an out-of-range word index.
// A redirect flushes the FIFO and restarts fetch at the new target.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   imem_addr            word index {2'b00, pc[31:2]} to instruction memory
//   imem_rdata           instruction returned combinationally for imem_addr
//   redirect_valid/_pc   load new byte target and flush the FIFO
//   dec_valid/_instr/_pc FIFO head towards decode
//   dec_ready            decode consumes the head this cycle
//   halted, fault        sequencer is in HALT / FAULT
//
// Optional: define FETCH_PERF_CNT_EN to add perf_fetch_cnt (pushes) and perf_stall_cnt
// (FETCH cycles blocked by a full FIFO with no pop).
module fetch_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        halted,
`ifdef FETCH_PERF_CNT_EN
    output logic        fault,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`else
    output logic        fault
`endif
);

    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW      = PtrW + 1;
    localparam logic [CntW-1:0] Full  = CntW'(FIFO_DEPTH);
    localparam logic [31:0] ImemWords = 32'(IMEM_WORDS);

    typedef enum logic [1:0] {StIdle, StFetch, StHalt, StFault} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       instr_buf_q [FIFO_DEPTH];
    logic [31:0]       instr_buf_d [FIFO_DEPTH];
    logic [31:0]       pc_buf_q [FIFO_DEPTH];
    logic [31:0]       pc_buf_d [FIFO_DEPTH];
    logic              halted_q, halted_d, fault_q, fault_d;

    logic pop, fetch_en, out_of_range, push, stall;

    // Byte-offset bits of the redirect target are intentionally dropped.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_addr    = {2'b00, pc_q[31:2]};
    assign dec_valid    = (count_q != '0);
    assign dec_instr    = instr_buf_q[rd_ptr_q];
    assign dec_pc       = pc_buf_q[rd_ptr_q];
    assign halted       = halted_q;
    assign fault        = fault_q;

    assign pop          = dec_valid && dec_ready;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign fetch_en     = (state_q == StFetch) && ((count_q < Full) || pop);
    assign out_of_range = (imem_addr >= ImemWords);
    assign push         = !redirect_valid && fetch_en && !out_of_range && (imem_rdata != '0);
    assign stall        = (state_q == StFetch) && (count_q == Full) && !pop;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_buf_d = instr_buf_q;
        pc_buf_d    = pc_buf_q;

        if (redirect_valid) begin
            state_d  = StFetch;
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_buf_d[wr_ptr_q] = imem_rdata;
                pc_buf_d[wr_ptr_q]    = pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
                pc_d                  = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            unique case (state_q)
                StIdle:  state_d = StFetch;
                StFetch: begin
                    if (fetch_en) begin
                        if (out_of_range) begin
                            state_d = StFault;
                        end else if (imem_rdata == '0) begin
                            state_d = StHalt;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end

        halted_d = (state_d == StHalt);
        fault_d  = (state_d == StFault);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_buf_q[i] <= '0;
                pc_buf_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            instr_buf_q <= instr_buf_d;
            pc_buf_q    <= pc_buf_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + (push ? 32'd1 : 32'd0);
        perf_stall_d = perf_stall_q + (stall ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: table-driven directed vectors, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_fetch_ctrl;

    localparam int DEPTH = 4;
    localparam int WORDS = 1024;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        halted;
    logic        fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [31:0] mem [0:WORDS-1];

    assign imem_rdata = (imem_addr < 32'(WORDS)) ? mem[imem_addr[9:0]] : 32'hFFFF_FFFF;

    fetch_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (32'h0),
        .IMEM_WORDS(WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready),
        .halted        (halted),
`ifdef FETCH_PERF_CNT_EN
        .fault         (fault),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`else
        .fault         (fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    int          m_mode;
    logic [31:0] m_fetches;
    logic [31:0] m_stalls;

    task automatic model_update(input logic rst, input logic rd, input logic [31:0] rpc,
                                input logic rdy);
        bit   pop, full;
        logic [31:0] word;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_pc      = 32'h0;
            m_mode    = M_IDLE;
            m_fetches = 0;
            m_stalls  = 0;
            return;
        end
        pop  = (m_q.size() != 0) && rdy;
        full = (m_q.size() == DEPTH);
        if (m_mode == M_RUN && full && !pop) m_stalls++;
        if (rd) begin
            m_q.delete();
            m_pc   = rpc & 32'hFFFF_FFFC;
            m_mode = M_RUN;
            return;
        end
        if (pop) m_q.delete(0);
        if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN && (!full || pop)) begin
            word = m_pc >> 2;
            if (word >= WORDS) begin
                m_mode = M_FAULT;
            end else if (mem[word[9:0]] == 32'h0) begin
                m_mode = M_HALT;
            end else begin
                e.pc    = m_pc;
                e.instr = mem[word[9:0]];
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
                m_fetches++;
            end
        end
    endtask

    task automatic compare_model();
        check("model.dec_valid", {31'b0, dec_valid}, {31'b0, m_q.size() != 0});
        check("model.halted", {31'b0, halted}, {31'b0, m_mode == M_HALT});
        check("model.fault", {31'b0, fault}, {31'b0, m_mode == M_FAULT});
        check("model.imem_addr", imem_addr, m_pc >> 2);
        if (m_q.size() != 0) begin
            check("model.dec_pc", dec_pc, m_q[0].pc);
            check("model.dec_instr", dec_instr, m_q[0].instr);
        end
`ifdef FETCH_PERF_CNT_EN
        check("model.perf_fetch", perf_fetch_cnt, m_fetches);
        check("model.perf_stall", perf_stall_cnt, m_stalls);
`endif
    endtask

    task automatic step(input logic rst, input logic rd, input logic [31:0] rpc,
                        input logic rdy);
        reset          = rst;
        redirect_valid = rd;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        @(posedge clk);
        model_update(rst, rd, rpc, rdy);
        #1;
        compare_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_halt;
        logic        e_fault;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        m_q.delete();
        m_pc      = 0;
        m_mode    = M_IDLE;
        m_fetches = 0;
        m_stalls  = 0;

        for (int i = 0; i < WORDS; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        mem[4] = 32'h0;

        //            rst   rd    rpc       rdy   valid chk   pc        instr         h     f     addr
        tbl[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h0,  32'h11,       1'b0, 1'b0, 32'h1};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h4,  32'h22,       1'b0, 1'b0, 32'h2};
        tbl[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h8,  32'h33,       1'b0, 1'b0, 32'h3};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hC,  32'h44,       1'b0, 1'b0, 32'h4};
        tbl[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h4};
        tbl[7] = '{1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h8};
        tbl[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h20, 32'h1000_0008, 1'b0, 1'b0, 32'h9};
        tbl[9] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h24, 32'h1000_0009, 1'b0, 1'b0, 32'hA};

        #1;
        for (int r = 0; r < 10; r++) begin
            step(tbl[r].rst, tbl[r].rd, tbl[r].rpc, tbl[r].rdy);
            check($sformatf("tbl%0d.dec_valid", r), {31'b0, dec_valid}, {31'b0, tbl[r].e_valid});
            check($sformatf("tbl%0d.halted", r), {31'b0, halted}, {31'b0, tbl[r].e_halt});
            check($sformatf("tbl%0d.fault", r), {31'b0, fault}, {31'b0, tbl[r].e_fault});
            check($sformatf("tbl%0d.imem_addr", r), imem_addr, tbl[r].e_addr);
            if (tbl[r].chk_data) begin
                check($sformatf("tbl%0d.dec_pc", r), dec_pc, tbl[r].e_pc);
                check($sformatf("tbl%0d.dec_instr", r), dec_instr, tbl[r].e_instr);
            end
        end

        // ---- stall with decode blocked, then pop+refill in one cycle ----
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h1000_0000 | 32'(i);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("stall.imem_addr", imem_addr, 32'h4);
        check("stall.dec_pc", dec_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("refill.imem_addr", imem_addr, 32'h5);
        check("refill.dec_pc", dec_pc, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("refill.still_full", imem_addr, 32'h5);

        // ---- redirect with 3 buffered, misaligned target ----
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h103, 1'b0);
        check("redir.flush_valid", {31'b0, dec_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("redir.valid", {31'b0, dec_valid}, 32'h1);
        check("redir.dec_pc", dec_pc, 32'h100);
        check("redir.dec_instr", dec_instr, 32'h1000_0040);

        // ---- out-of-range fetch, then recover ----
        step(1'b0, 1'b1, 32'h1000, 1'b0);
        check("oor.addr", imem_addr, 32'h400);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("oor.fault", {31'b0, fault}, 32'h1);
        check("oor.no_push", {31'b0, dec_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("oor.fault_holds", {31'b0, fault}, 32'h1);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("oor.cleared", {31'b0, fault}, 32'h0);

        // ---- reset with FIFO full and pop pending ----
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("full.before_reset", {31'b0, dec_valid}, 32'h1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("rst.dec_valid", {31'b0, dec_valid}, 32'h0);
        check("rst.halted", {31'b0, halted}, 32'h0);
        check("rst.fault", {31'b0, fault}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst.perf_fetch", perf_fetch_cnt, 32'h0);
        check("rst.perf_stall", perf_stall_cnt, 32'h0);
`endif

        // ---- randomized traffic against the model ----
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_rd, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 99) == 0);
            r_rd  = ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_pc  = 32'($urandom_range(0, 32'h1080));
            step(r_rst, r_rd, r_pc, r_rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the word-addressed, combinational-read instruction memory.
- Each fetched word, tagged with its PC, is pushed into a small FIFO.
- Decode drains the FIFO through a valid/ready handshake.
- Supports redirect (branch/jump), halt on an all-zero instruction, and fault on out-of-range fetch.
- Sits between the instruction memory and the decode stage of the single-cycle/pipelined core.

Parameters:
FIFO_DEPTH, 4, fetch-buffer entries; power of two, >= 2
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset
IMEM_WORDS, 1024, instruction-memory depth in 32-bit words; word index >= IMEM_WORDS is out of range

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  word index to instruction memory = {2'b00, pc_q[31:2]}
imem_rdata  input  32  instruction returned combinationally for imem_addr
redirect_valid  input  1  load redirect_pc and flush this cycle
redirect_pc  input  32  byte address of new fetch target
dec_valid  output  1  FIFO head holds a valid instruction
dec_instr  output  32  instruction at FIFO head
dec_pc  output  32  byte PC of FIFO head
dec_ready  input  1  decode accepts the head this cycle
halted  output  1  state == HALT
fault  output  1  state == FAULT

Behaviour:
- Reset, sampled at a rising edge with reset=1:
  - pc_q=RESET_PC, state=IDLE.
  - FIFO pointers and count cleared.
  - dec_valid=0, halted=0, fault=0.
  - dec_instr and dec_pc read the cleared head entry (32'h0).
- Reset mid-operation discards all buffered instructions.
- States are IDLE, FETCH, HALT and FAULT.
- IDLE: no push; moves to FETCH on the next edge.
- FETCH: fetch is enabled when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs this cycle. When enabled:
  - If imem_addr >= IMEM_WORDS: go to FAULT, no push, pc_q unchanged.
  - Else if imem_rdata == 32'h0: go to HALT, no push, pc_q unchanged.
  - Else: push {pc_q, imem_rdata} and set pc_q <= pc_q + 4. The PC wraps mod 2^32.
- FETCH with the FIFO full and no pop: stall; pc_q holds.
- HALT and FAULT: no fetch. The FIFO keeps draining normally. Exit only via redirect or reset.
- Pop occurs when dec_valid && dec_ready.
- dec_valid = (count != 0). There is no bypass: a push into an empty FIFO makes dec_valid=1 on the next cycle.
- Push and pop in the same cycle: count unchanged. This is legal when full and also when count==1.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count ranges 0..FIFO_DEPTH.
- Redirect has the highest priority, above fetch, halt and fault:
  - FIFO flushed (count=0), so dec_valid=0 next cycle.
  - pc_q <= {redirect_pc[31:2], 2'b00}; misaligned low bits are dropped.
  - state <= FETCH from any state except IDLE; IDLE still goes to FETCH.
  - No push occurs in the redirect cycle.
  - A pop handshake in the same cycle counts as consumed by decode.
- Latency:
  - First fetch happens at the second edge after reset deasserts. dec_valid rises the cycle after that.
  - Redirect to first dec_valid: 2 cycles (flush edge, then fetch edge).
- Throughput: 1 instruction per cycle when decode is always ready.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds two outputs, each 32 bits, cleared by reset, wrapping at 2^32.
  - perf_fetch_cnt increments on every push.
  - perf_stall_cnt increments on every FETCH cycle where fetch is blocked by a full FIFO with no pop.
- Undefined: neither port nor its counter logic exists. All other behaviour is identical.

Test Plan:
- Load imem words 0..3 = 32'h11,22,33,44, then word 4 = 0; hold dec_ready=1 and release reset -> dec_pc 0,4,8,C in consecutive cycles with matching instrs; halted=1 after the zero word; dec_valid=0 once the FIFO drains.
- Hold dec_ready=0 with FIFO_DEPTH=4 and non-zero imem -> exactly 4 pushes, dec_pc stays 0, pc_q stalls at 0x10; dec_ready=1 for one cycle -> pop one and refill in the same cycle, count stays 4.
- After 3 instructions are buffered, pulse redirect_valid with redirect_pc=0x103 -> next cycle dec_valid=0; the cycle after, dec_pc=0x100 with instr = imem word 0x40.
- Issue a redirect while in HALT (the state reached in the first scenario) to 0x20 -> halted=0 next cycle and fetch resumes from word 8.
- Redirect to 0x1000 (word 1024) with IMEM_WORDS=1024 -> fault=1, no push, dec_valid stays 0; redirect to 0x0 clears fault.
- Assert reset with the FIFO full and a pop pending -> next cycle dec_valid=0, halted=0, fault=0; with FETCH_PERF_CNT_EN defined, both counters read 0.
